// File: rtl/addmul_sequencer.sv
// addmul_sequencer: sequencing engine for the shared adder-multiplier.
// One operation per accepted start: a single-cycle add, or a W-cycle
// shift-add multiply, followed by a one-cycle DONE state that presents the
// registered 2W-bit result together with the done pulse.
module addmul_sequencer #(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           rejected
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

  logic [1:0]       state;
  logic [W-1:0]     mcand;
  logic [W-1:0]     mplr;
  logic [2*W-1:0]   acc;
  logic [CNT_W-1:0] count;

  logic [W:0]       sum_add;
  logic [W:0]       sum_mul;
  logic [2*W-1:0]   acc_add;
  logic [2*W-1:0]   acc_mul;

  // Next accumulator values for one add step and one shift-add multiply step.
  // The multiply keeps the partial product in acc: the upper half gains the
  // multiplicand when the current multiplier bit is set, then the whole
  // W+1-bit sum plus the lower half shift right, so finished product bits
  // migrate into the lower half and nothing is ever truncated.
  always_comb begin
    sum_add = {1'b0, mcand} + {1'b0, mplr};
    acc_add = {{(W-1){1'b0}}, sum_add};
    sum_mul = {1'b0, acc[2*W-1:W]} + (mplr[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    acc_mul = {sum_mul, acc[W-1:1]};
  end

  // Main FSM with operand/accumulator datapath. The result register is
  // loaded on the edge that enters DONE so it is already valid while done
  // is high, and it holds until the next operation finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplr   <= '0;
      acc    <= '0;
      count  <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            mplr  <= b;
            acc   <= '0;
            count <= '0;
            state <= op ? MUL : ADD;
          end
        end
        ADD: begin
          acc    <= acc_add;
          result <= acc_add;
          state  <= DONE;
        end
        MUL: begin
          acc   <= acc_mul;
          mplr  <= mplr >> 1;
          count <= count + 1'b1;
          if (count == LAST_ITER) begin
            result <= acc_mul;
            state  <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status decoded straight from state; a start outside IDLE is dropped and
  // flagged in the same cycle it is presented.
  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    rejected = start && (state != IDLE);
  end

endmodule

// File: tb/tb_addmul_sequencer.sv
// Bench for addmul_sequencer: directed and random operations checked
// against a plain-arithmetic reference for result value and latency.
module tb_addmul_sequencer;

  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic           op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           rejected;

  int total;
  int bad;

  addmul_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rejected (rejected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one operation and follows it to its done pulse. Returns in the
  // DONE cycle so a following call can start in the very next IDLE cycle.
  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input string tag);
    logic [2*W-1:0] exp_r;
    int             exp_lat;
    int             n;
    bit             seen;
    exp_r   = o ? (2*W)'(x) * (2*W)'(y) : (2*W)'(x) + (2*W)'(y);
    exp_lat = o ? W + 1 : 2;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    #1 chk({tag, "_rej_idle"}, 32'(rejected), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0; op = 1'($urandom); a = W'($urandom); b = W'($urandom);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      else if (!busy) begin
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        n = 40;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_result"}, 32'(result), 32'(exp_r));
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
  endtask

  initial begin
    int             dones;
    bit             rej_seen;
    logic           ro;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [2*W-1:0] rexp;

    total = 0; bad = 0;

    // Reset with busy-looking random inputs.
    rst = 1'b1; start = 1'b1; op = 1'($urandom); a = W'($urandom); b = W'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rej", 32'(rejected), 32'd0);
    chk("rst_result", 32'(result), 32'h0000);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Directed add and multiplies.
    run_op(1'b0, 8'd200, 8'd100, "add200_100");
    chk("add_value", 32'(result), 32'h012C);
    @(negedge clk);
    chk("add_done_pulse", 32'(done), 32'd0);
    chk("add_idle_busy", 32'(busy), 32'd0);
    chk("add_hold", 32'(result), 32'h012C);
    run_op(1'b1, 8'd255, 8'd255, "mul255");
    chk("mul255_value", 32'(result), 32'hFE01);
    run_op(1'b1, 8'd13, 8'd11, "mul13_11");
    chk("mul13_value", 32'(result), 32'h008F);
    run_op(1'b1, 8'd0, 8'd77, "mul0_77");

    // Start presented mid-multiply is rejected and does not disturb it.
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 8'd3; b = 8'd5;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0; rej_seen = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 3) begin
        start = 1'b1; op = 1'b0; a = 8'd1; b = 8'd1;
        #1 rej_seen = rejected;
        @(posedge clk);
        #1 start = 1'b0;
      end else if (done) begin
        dones++;
      end
    end
    chk("rej_pulse", 32'(rej_seen), 32'd1);
    chk("rej_one_done", 32'(dones), 32'd1);
    chk("rej_result", 32'(result), 32'h000F);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 8'd200; b = 8'd200;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'h0000);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run_op(1'b0, 8'd1, 8'd1, "add1_1");
    chk("add1_value", 32'(result), 32'h0002);

    // Back-to-back: next start in the IDLE cycle right after DONE.
    @(negedge clk);
    run_op(1'b0, 8'd255, 8'd255, "b2b_add");
    chk("b2b_add_value", 32'(result), 32'h01FE);
    run_op(1'b1, 8'd2, 8'd3, "b2b_mul");
    chk("b2b_mul_value", 32'(result), 32'h0006);

    // Random operations against the arithmetic reference.
    for (int k = 0; k < 24; k++) begin
      ro = 1'($urandom); ra = W'($urandom); rb = W'($urandom);
      if (k == 0) begin ra = 8'd0; rb = 8'd0; end
      if (k == 1) begin ro = 1'b1; ra = 8'd255; rb = 8'd1; end
      rexp = ro ? (2*W)'(ra) * (2*W)'(rb) : (2*W)'(ra) + (2*W)'(rb);
      run_op(ro, ra, rb, "rand");
      @(negedge clk);
      chk("rand_idle_done", 32'(done), 32'd0);
      chk("rand_hold", 32'(result), 32'(rexp));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
